// File: rtl/matrix_ring_counter_pkg.sv
// Shared phase constants, FSM state encoding and phase helpers for the
// matrix ring scan sequencer.
package matrix_ring_counter_pkg;

  localparam logic [2:0] PHASE_OFF = 3'b000;
  localparam logic [2:0] PHASE_C0  = 3'b001;  // col0 / col4
  localparam logic [2:0] PHASE_C1  = 3'b010;  // col1 / col3
  localparam logic [2:0] PHASE_C2  = 3'b100;  // col2

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // True only for one of the three legal scan phases.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == PHASE_C0) || (v == PHASE_C1) || (v == PHASE_C2);
  endfunction

  // Column index (0..2) of the half image addressed by a phase.
  function automatic logic [1:0] phase_idx(input logic [2:0] v);
    case (v)
      PHASE_C1: return 2'd1;
      PHASE_C2: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

  // Scan order 001 -> 010 -> 100 -> 001.
  function automatic logic [2:0] next_phase(input logic [2:0] v);
    case (v)
      PHASE_C0: return PHASE_C1;
      PHASE_C1: return PHASE_C2;
      default:  return PHASE_C0;
    endcase
  endfunction

endpackage

// File: rtl/matrix_ring_counter_prescaler.sv
// Loadable down-counter with terminal-count flag. Counts down to zero and
// holds there; zero_next_o looks one edge ahead so callers can register
// outputs that must line up with the terminal cycle.
module matrix_prescaler #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o,
  output logic         zero_next_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n)                       cnt_q <= '0;
    else if (load_i)                  cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign tc_o        = (cnt_q == '0);
  assign zero_next_o = load_i ? (load_val_i == '0)
                              : ((cnt_q == '0) || (dec_i && cnt_q == W'(1)));

endmodule

// File: rtl/matrix_ring_counter.sv
// Scan sequencer for the matrix ring decoder: steps a one-hot column phase,
// holds each for CLK_DIV cycles, inserts BLANK_CYCLES all-off cycles between
// phases and latches the half image once per frame at the 001 entry.
module matrix_ring_counter
  import matrix_ring_counter_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 4,
  parameter int ROWS         = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [3*ROWS-1:0] image_half,
  output logic [2:0]        ring_counter,
  output logic [ROWS-1:0]   rows,
  output logic              frame_tick
);

  localparam int DW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [2:0]        ring_q, ring_d;
  logic [2:0]        pend_q, pend_d;   // phase to show after the blanking gap
  logic [ROWS-1:0]   rows_q, rows_d;
  logic              tick_q, tick_d;
  logic [3*ROWS-1:0] latch_q, latch_d;

  logic dwell_load, dwell_tc, dwell_zn;
  logic blank_load, blank_tc, blank_zn_unused;

  matrix_prescaler #(.W(DW)) u_dwell (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (dwell_load),
    .load_val_i  (DWELL_LOAD),
    .dec_i       (state_q == ST_SHOW),
    .tc_o        (dwell_tc),
    .zero_next_o (dwell_zn)
  );

  matrix_prescaler #(.W(BW)) u_blank (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (blank_load),
    .load_val_i  (BLANK_LOAD),
    .dec_i       (state_q == ST_BLANK),
    .tc_o        (blank_tc),
    .zero_next_o (blank_zn_unused)
  );

  // Next-state decode; every output is computed here and registered below.
  always_comb begin
    state_d    = state_q;
    ring_d     = ring_q;
    pend_d     = pend_q;
    latch_d    = latch_q;
    dwell_load = 1'b0;
    blank_load = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      ring_d  = PHASE_OFF;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SHOW;
          ring_d     = PHASE_C0;
          latch_d    = image_half;
          dwell_load = 1'b1;
        end
        ST_SHOW: begin
          if (!is_onehot3(ring_q)) begin
            // Corrupted phase: restart the frame cleanly.
            ring_d     = PHASE_C0;
            latch_d    = image_half;
            dwell_load = 1'b1;
          end else if (dwell_tc) begin
            if (BLANK_CYCLES > 0) begin
              state_d    = ST_BLANK;
              ring_d     = PHASE_OFF;
              pend_d     = next_phase(ring_q);
              blank_load = 1'b1;
            end else begin
              ring_d     = next_phase(ring_q);
              dwell_load = 1'b1;
              if (ring_d == PHASE_C0) latch_d = image_half;
            end
          end
        end
        ST_BLANK: begin
          if (blank_tc) begin
            state_d    = ST_SHOW;
            ring_d     = pend_q;
            dwell_load = 1'b1;
            if (pend_q == PHASE_C0) latch_d = image_half;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ring_d  = PHASE_OFF;
        end
      endcase
    end
    rows_d = (state_d == ST_SHOW) ? latch_d[int'(phase_idx(ring_d))*ROWS +: ROWS] : '0;
    tick_d = (state_d == ST_SHOW) && (ring_d == PHASE_C2) && dwell_zn;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ring_q  <= PHASE_OFF;
      pend_q  <= PHASE_C0;
      rows_q  <= '0;
      tick_q  <= 1'b0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      pend_q  <= pend_d;
      rows_q  <= rows_d;
      tick_q  <= tick_d;
      latch_q <= latch_d;
    end
  end

  assign ring_counter = ring_q;
  assign rows         = rows_q;
  assign frame_tick   = tick_q;

endmodule
